hdu_unit: RTL and testbench

HDU_UNIT -- requirements
Module: hdu_unit

---
 rtl/hdu_unit.sv | 84 ++++++++
 tb/tb_hdu_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hdu_unit.sv
// Hazard detection for a 4-stage pipeline: flags a read-after-write conflict
// between the decode-stage instruction and any in-flight writer.
module hdu_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ID_instruct,
  input  logic [7:0] EX_instruct,
  input  logic [7:0] MEM_instruct,
  input  logic [7:0] WB_instruct,
  output logic       stall,
  output logic       out
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_INC = 3'b011;

  logic [2:0] id_op;
  logic [1:0] id_reg1;
  logic [1:0] id_reg2;
  logic       id_rd1;
  logic       id_rd2;

  logic       ex_wr;
  logic       mem_wr;
  logic       wb_wr;
  logic [1:0] ex_dst;
  logic [1:0] mem_dst;
  logic [1:0] wb_dst;

  logic       hazard_ex;
  logic       hazard_mem;
  logic       hazard_wb;

  // Mode bit is architecturally irrelevant to hazard detection.
  logic       unused_mode;

  assign unused_mode = ^{ID_instruct[7], EX_instruct[7],
                         MEM_instruct[7], WB_instruct[7]};

  assign id_op   = ID_instruct[6:4];
  assign id_reg1 = ID_instruct[3:2];
  assign id_reg2 = ID_instruct[1:0];

  // INC only consumes its destination register, so reg2 is not a source.
  assign id_rd1 = (id_op != OP_NOP);
  assign id_rd2 = (id_op != OP_NOP) && (id_op != OP_INC);

  assign ex_wr  = (EX_instruct[6:4]  != OP_NOP);
  assign mem_wr = (MEM_instruct[6:4] != OP_NOP);
  assign wb_wr  = (WB_instruct[6:4]  != OP_NOP);

  assign ex_dst  = EX_instruct[3:2];
  assign mem_dst = MEM_instruct[3:2];
  assign wb_dst  = WB_instruct[3:2];

  always_comb begin
    hazard_ex  = 1'b0;
    hazard_mem = 1'b0;
    hazard_wb  = 1'b0;
    if (ex_wr) begin
      hazard_ex = (id_rd1 && (id_reg1 == ex_dst)) ||
                  (id_rd2 && (id_reg2 == ex_dst));
    end
    if (mem_wr) begin
      hazard_mem = (id_rd1 && (id_reg1 == mem_dst)) ||
                   (id_rd2 && (id_reg2 == mem_dst));
    end
    if (wb_wr) begin
      hazard_wb = (id_rd1 && (id_reg1 == wb_dst)) ||
                  (id_rd2 && (id_reg2 == wb_dst));
    end
  end

  assign stall = hazard_ex | hazard_mem | hazard_wb;

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= 1'b0;
    end else begin
      out <= stall;
    end
  end

endmodule

// File: tb/tb_hdu_unit.sv
// Scoreboard bench for hdu_unit: a register-mask reference model predicts
// stall immediately and the registered out one edge later.
module tb_hdu_unit;

  logic       clk;
  logic       reset;
  logic [7:0] id_i, ex_i, mem_i, wb_i;
  logic       stall;
  logic       out;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  hdu_unit dut (
    .clk          (clk),
    .reset        (reset),
    .ID_instruct  (id_i),
    .EX_instruct  (ex_i),
    .MEM_instruct (mem_i),
    .WB_instruct  (wb_i),
    .stall        (stall),
    .out          (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] wr_mask(input logic [7:0] ins);
    if (ins[6:4] == 3'd0) return 4'b0000;
    return 4'b0001 << ins[3:2];
  endfunction

  function automatic logic [3:0] rd_mask(input logic [7:0] ins);
    logic [3:0] m;
    m = 4'b0000;
    if (ins[6:4] != 3'd0) m = m | (4'b0001 << ins[3:2]);
    if (ins[6:4] != 3'd0 && ins[6:4] != 3'd3) m = m | (4'b0001 << ins[1:0]);
    return m;
  endfunction

  function automatic bit model(input logic [7:0] a, b, c, d);
    return |(rd_mask(a) & (wr_mask(b) | wr_mask(c) | wr_mask(d)));
  endfunction

  // Drives one vector at the falling edge and queues the value out must
  // carry after the next rising edge.
  task automatic drive(input logic [7:0] a, b, c, d, input logic r);
    @(negedge clk);
    id_i = a; ex_i = b; mem_i = c; wb_i = d; reset = r;
    #1;
    exp_q.push_back(r ? 1'b0 : model(a, b, c, d));
  endtask

  task automatic test_reset();
    bit e;
    drive(8'h11, 8'h12, 8'h00, 8'h00, 1'b1);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (out !== e) begin
      errors++;
      $display("FAIL reset_out: got %b expected %b", out, e);
    end
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_live: got %b expected 1", stall);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vec [10];
    bit req [10];
    bit e;
    vec[0] = 32'h00_00_00_00; req[0] = 1'b0;
    vec[1] = 32'h11_12_00_00; req[1] = 1'b1;
    vec[2] = 32'h14_12_00_00; req[2] = 1'b1;
    vec[3] = 32'h34_11_00_00; req[3] = 1'b0;
    vec[4] = 32'h16_00_14_00; req[4] = 1'b1;
    vec[5] = 32'h11_00_00_12; req[5] = 1'b1;
    vec[6] = 32'h11_18_00_00; req[6] = 1'b0;
    vec[7] = 32'h91_98_80_80; req[7] = 1'b0;
    vec[8] = 32'h00_12_10_1C; req[8] = 1'b0;
    vec[9] = 32'h11_10_10_10; req[9] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(vec[i][31:24], vec[i][23:16], vec[i][15:8], vec[i][7:0], 1'b0);
      checks++;
      if (stall !== req[i]) begin
        errors++;
        $display("FAIL directed_stall[%0d]: got %b expected %b", i, stall, req[i]);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (out !== e) begin
        errors++;
        $display("FAIL directed_out[%0d]: got %b expected %b", i, out, e);
      end
    end
  endtask

  task automatic test_mode_bit();
    logic [7:0] a, b, c, d;
    bit e0;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      drive(a & 8'h7F, b & 8'h7F, c & 8'h7F, d & 8'h7F, 1'b0);
      e0 = stall;
      void'(exp_q.pop_front());
      #1;
      id_i = a | 8'h80; ex_i = b | 8'h80; mem_i = c | 8'h80; wb_i = d | 8'h80;
      #1;
      checks++;
      if (stall !== model(a & 8'h7F, b & 8'h7F, c & 8'h7F, d & 8'h7F) || stall !== e0) begin
        errors++;
        $display("FAIL mode_bit[%0d]: got %b expected %b", i, stall, e0);
      end
      exp_q.push_back(model(a, b, c, d));
      @(posedge clk); #1;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset_mid_stall();
    bit e;
    bit rs [3];
    rs[0] = 1'b0; rs[1] = 1'b1; rs[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(8'h11, 8'h12, 8'h00, 8'h00, rs[i]);
      checks++;
      if (stall !== 1'b1) begin
        errors++;
        $display("FAIL midreset_stall[%0d]: got %b expected 1", i, stall);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (out !== e) begin
        errors++;
        $display("FAIL midreset_out[%0d]: got %b expected %b", i, out, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b, c, d;
    bit e;
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      if (i % 5 == 0) b = {1'b0, 3'($urandom_range(1, 7)), a[3:2], 2'($urandom)};
      drive(a, b, c, d, ($urandom_range(0, 19) == 0));
      checks++;
      if (stall !== model(a, b, c, d)) begin
        errors++;
        $display("FAIL b2b_stall[%0d]: got %b expected %b", i, stall, model(a, b, c, d));
      end
      @(posedge clk); #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_queue[%0d]: got empty expected entry", i);
      end else begin
        e = exp_q.pop_front();
        if (out !== e) begin
          errors++;
          $display("FAIL b2b_out[%0d]: got %b expected %b", i, out, e);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    id_i = 8'h00; ex_i = 8'h00; mem_i = 8'h00; wb_i = 8'h00;
    test_reset();
    test_directed();
    test_mode_bit();
    test_reset_mid_stall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
